// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single-port program/data memory of the accumulator processor
// between instruction fetch (0), control-unit data access (1) and the I/O
// port (2). One access at a time: IDLE -> ACCESS (WAIT_STATES+1 cycles) ->
// RESP (one-cycle ack) -> IDLE.
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration;
// otherwise fixed priority data(1) > fetch(0) > io(2).

module mem_port_arbiter #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [2:0]          req,
    input  logic [2:0]          req_we,
    input  logic [3*ADDR_W-1:0] req_addr,
    input  logic [3*DATA_W-1:0] req_wdata,
    output logic [2:0]          ack,
    output logic [2:0]          grant,
    output logic [DATA_W-1:0]   rdata,
    output logic                busy,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t              state;
    logic   [3:0]        wait_cnt;
    logic   [1:0]        win_idx;
    logic   [ADDR_W-1:0] sel_addr;
    logic   [DATA_W-1:0] sel_wdata;
    logic                sel_we;

`ifdef MEM_ARB_RR_EN
    logic [1:0] rr_ptr;
    logic [1:0] cand;
    logic       found;

    // Round-robin pick: search from the requester after the last winner
    always_comb begin
        win_idx = 2'd0;
        found   = 1'b0;
        cand    = (rr_ptr == 2'd2) ? 2'd0 : rr_ptr + 2'd1;
        for (int k = 0; k < 3; k++) begin
            if (!found && req[cand]) begin
                win_idx = cand;
                found   = 1'b1;
            end
            cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
        end
    end

    // Remember the last winner so the next search starts just past it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr <= 2'd2;
        end else if (state == IDLE && |req) begin
            rr_ptr <= win_idx;
        end
    end
`else
    // Fixed priority pick: data beats fetch, io only when nobody else asks
    always_comb begin
        win_idx = 2'd2;
        if (req[1]) begin
            win_idx = 2'd1;
        end else if (req[0]) begin
            win_idx = 2'd0;
        end
    end
`endif

    // Route the winner's address/data/write-enable; fetch is read-only so its
    // write enable is masked off
    always_comb begin
        sel_addr  = req_addr[ADDR_W-1:0];
        sel_wdata = req_wdata[DATA_W-1:0];
        sel_we    = req_we[0] & 1'b0;
        case (win_idx)
            2'd1: begin
                sel_addr  = req_addr[2*ADDR_W-1:ADDR_W];
                sel_wdata = req_wdata[2*DATA_W-1:DATA_W];
                sel_we    = req_we[1];
            end
            2'd2: begin
                sel_addr  = req_addr[3*ADDR_W-1:2*ADDR_W];
                sel_wdata = req_wdata[3*DATA_W-1:2*DATA_W];
                sel_we    = req_we[2];
            end
            default: ;
        endcase
    end

    // Access sequencer: all memory-side and handshake outputs are registered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ack       <= '0;
            grant     <= '0;
            busy      <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
            wait_cnt  <= '0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant     <= 3'b001 << win_idx;
                        mem_en    <= 1'b1;
                        mem_we    <= sel_we;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        busy      <= 1'b1;
                        wait_cnt  <= '0;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (wait_cnt == 4'(WAIT_STATES)) begin
                        if (!mem_we) begin
                            rdata <= mem_rdata;
                        end
                        mem_en    <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        wait_cnt  <= '0;
                        ack       <= grant;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                RESP: begin
                    grant <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter with WAIT_STATES=1. Expected acks and
// read data are queued when a request is issued and popped by a monitor
// whenever the arbiter pulses ack. Honours MEM_ARB_RR_EN for arbitration order.

module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic [2:0]  req;
    logic [2:0]  req_we;
    logic [23:0] req_addr;
    logic [23:0] req_wdata;
    logic [2:0]  ack;
    logic [2:0]  grant;
    logic [7:0]  rdata;
    logic        busy;
    logic        mem_en;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    logic [7:0]  mem [256];

    typedef struct {
        logic [2:0] ack;
        logic [7:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rr_last = 2;

    mem_port_arbiter #(
        .ADDR_W(8),
        .DATA_W(8),
        .WAIT_STATES(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .req_we(req_we),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .ack(ack),
        .grant(grant),
        .rdata(rdata),
        .busy(busy),
        .mem_en(mem_en),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Free-running clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: combinational read, write on clock edge, preloaded at reset
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            mem[8'h10] <= 8'hA5;
            mem[8'h30] <= 8'h5A;
        end else if (mem_en && mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] r, input logic [2:0] we,
                                 input logic [23:0] addr, input logic [23:0] wdata);
        req       = r;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
    endtask

    // Wait (bounded) for the next ack pulse; returns the cycle it was seen
    task automatic waitAck(input string tag, output int at);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack === 3'b000 && n < 20);
        checkOutput({tag, "_ack_seen"}, 32'(ack !== 3'b000), 32'd1);
        at = cyc;
    endtask

    // One isolated access with cycle-accurate checks of the memory interface
    task automatic runAccess(input int idx, input logic we, input logic [7:0] addr,
                             input logic [7:0] wdata, input logic [7:0] exp_rdata);
        logic [2:0] onehot;
        onehot = 3'(1 << idx);
        sb.push_back('{onehot, exp_rdata});
        applyStimulus(onehot, we ? onehot : 3'b000, {3{addr}}, {3{wdata}});
        @(negedge clk);
        checkOutput("acc1_grant", grant, onehot);
        checkOutput("acc1_en", mem_en, 1);
        checkOutput("acc1_we", mem_we, we);
        checkOutput("acc1_addr", mem_addr, addr);
        if (we) checkOutput("acc1_wdata", mem_wdata, wdata);
        @(negedge clk);
        checkOutput("acc2_en", mem_en, 1);
        checkOutput("acc2_addr", mem_addr, addr);
        checkOutput("acc2_we", mem_we, we);
        @(negedge clk);
        checkOutput("resp_ack", ack, onehot);
        checkOutput("resp_en", mem_en, 0);
        checkOutput("resp_busy", busy, 1);
        applyStimulus(3'b000, 3'b000, 24'h0, 24'h0);
        @(negedge clk);
        checkOutput("idle_grant", grant, 0);
        checkOutput("idle_busy", busy, 0);
        rr_last = idx;
    endtask

    // Scoreboard monitor: every ack must match the oldest expected entry
    always @(negedge clk) begin
        if (reset && ack !== 3'b000) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_ack", ack, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("sb_ack", ack, e.ack);
                checkOutput("sb_rdata", rdata, e.rdata);
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence
    initial begin
        int t0, t1, t2;
        int ptr;
        reset = 1'b0;
        applyStimulus(3'b000, 3'b000, 24'h0, 24'h0);
        #1;
        checkOutput("rst_ack", ack, 0);
        checkOutput("rst_grant", grant, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_mem_en", mem_en, 0);
        checkOutput("rst_mem_we", mem_we, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        checkOutput("rst_mem_wdata", mem_wdata, 0);
        checkOutput("rst_rdata", rdata, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Reset asserted in the middle of an access aborts it without ack
        $display("[TB] reset mid-access");
        applyStimulus(3'b001, 3'b000, {3{8'h10}}, 24'h0);
        @(negedge clk);
        checkOutput("t1_en_before", mem_en, 1);
        #2 reset = 1'b0;
        #1;
        checkOutput("t1_en", mem_en, 0);
        checkOutput("t1_grant", grant, 0);
        checkOutput("t1_busy", busy, 0);
        checkOutput("t1_addr", mem_addr, 0);
        checkOutput("t1_ack", ack, 0);
        applyStimulus(3'b000, 3'b000, 24'h0, 24'h0);
        @(negedge clk);
        reset = 1'b1;
        rr_last = 2;
        repeat (4) @(negedge clk);
        checkOutput("t1_idle_busy", busy, 0);
        checkOutput("t1_idle_en", mem_en, 0);

        // Fetch read, data write, readback by fetch
        $display("[TB] fetch read / data write / readback");
        runAccess(0, 1'b0, 8'h10, 8'h00, 8'hA5);
        runAccess(1, 1'b1, 8'h20, 8'h3C, 8'hA5);
        runAccess(0, 1'b0, 8'h20, 8'h00, 8'h3C);

        // All three requesting continuously for six accesses
        $display("[TB] contention");
        ptr = rr_last;
        for (int i = 0; i < 6; i++) begin
`ifdef MEM_ARB_RR_EN
            ptr = (ptr + 1) % 3;
`else
            ptr = 1;
`endif
            case (ptr)
                0: sb.push_back('{3'b001, 8'hA5});
                1: sb.push_back('{3'b010, 8'h3C});
                default: sb.push_back('{3'b100, 8'h5A});
            endcase
        end
        rr_last = ptr;
        applyStimulus(3'b111, 3'b000, {8'h30, 8'h20, 8'h10}, 24'h0);
        for (int i = 0; i < 6; i++) waitAck("t4", t0);
        applyStimulus(3'b000, 3'b000, 24'h0, 24'h0);
        repeat (3) @(negedge clk);
        checkOutput("t4_drained", sb.size(), 0);

        // Request withdrawn after one access cycle still completes
        $display("[TB] request dropped mid-access");
        sb.push_back('{3'b001, 8'hA5});
        applyStimulus(3'b001, 3'b000, {3{8'h10}}, 24'h0);
        @(negedge clk);
        applyStimulus(3'b000, 3'b000, 24'h0, 24'h0);
        waitAck("t5", t0);
        rr_last = 0;
        repeat (5) @(negedge clk);
        checkOutput("t5_drained", sb.size(), 0);

        // Back-to-back fetches with req held high through ack
        $display("[TB] back-to-back");
        repeat (3) sb.push_back('{3'b001, 8'h5A});
        applyStimulus(3'b001, 3'b000, {3{8'h30}}, 24'h0);
        waitAck("t6a", t0);
        waitAck("t6b", t1);
        checkOutput("t6_period1", t1 - t0, 4);
        waitAck("t6c", t2);
        applyStimulus(3'b000, 3'b000, 24'h0, 24'h0);
        checkOutput("t6_period2", t2 - t1, 4);
        repeat (5) @(negedge clk);
        checkOutput("final_drained", sb.size(), 0);
        checkOutput("final_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
